// File: rtl/button_bank_if.sv
// button_bank_if: groups the raw button levels, mode controls and the pulse/level outputs.
//   in           raw asynchronous button levels, 1 = pressed
//   release_mode 0 = pulse on press edge, 1 = pulse on release edge
//   repeat_en    enables hold-to-auto-repeat in press mode
//   out          one-cycle action pulse per channel
//   held         debounced level per channel
interface button_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic                release_mode;
    logic                repeat_en;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] held;
    modport master (output in, release_mode, repeat_en, input out, held);
    modport slave (input in, release_mode, repeat_en, output out, held);
endinterface

// File: rtl/button_bank.sv
// button_bank: per-channel synchroniser, debouncer, edge pulse generator and auto-repeat.
//   clock  system clock, rising edge
//   reset  synchronous active-high, clears all state
//   bus    button_bank_if slave: in/release_mode/repeat_en in, out/held out
module button_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_RATE     = 250
) (
    input logic         clock,
    input logic         reset,
    button_bank_if.slave bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic          sync1, sync2, held, out;
        logic          flip, rise, fall, abort, rep_pulse;
        logic [CW-1:0] cnt;
        logic [RW-1:0] rcnt, rcnt_n;
        state_t        state, state_n;

        assign flip  = (sync2 != held) && (cnt == CNT_LAST);
        assign rise  = flip & ~held;
        assign fall  = flip & held;
        // A release, disabling repeat or switching to release mode kills any repeat in progress.
        assign abort = fall | ~bus.repeat_en | bus.release_mode;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                cnt   <= '0;
                held  <= 1'b0;
                out   <= 1'b0;
            end else begin
                sync1 <= bus.in[c];
                sync2 <= sync1;
                cnt   <= (flip || sync2 == held) ? '0 : cnt + 1'b1;
                held  <= held ^ flip;
                out   <= (bus.release_mode ? fall : rise) | rep_pulse;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                state <= state_n;
                rcnt  <= rcnt_n;
            end
        end

        // Only a press edge seen in press mode with repeat enabled arms the repeat timer.
        always_comb begin
            state_n = abort ? IDLE :
                      state == IDLE ? (rise ? DELAY : IDLE) :
                      (state == DELAY && rcnt == DELAY_LAST) ? REPEAT : state;
            rcnt_n  = (abort || state == IDLE || rep_pulse) ? '0 : rcnt + 1'b1;
        end

        always_comb begin
            rep_pulse = !abort && (state == DELAY  ? rcnt == DELAY_LAST :
                                   state == REPEAT && rcnt == RATE_LAST);
        end

        assign bus.out[c]  = out;
        assign bus.held[c] = held;
    end
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: randomized and directed stimulus, reference model feeding a scoreboard queue.
module tb_button_bank;
    localparam int CH = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    button_bank_if #(.CHANNELS(CH)) bus ();

    button_bank #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [2*CH-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [CH-1:0] p1 = '0, p2 = '0, m_held = '0, m_out;
    bit   hist[CH][$];
    bit   active[CH];
    int   tp[CH];
    int   n = 0;
    bit   stable, rise, fall;

    // Reference model: held flips once the last DB synchronised samples all disagree with it;
    // repeats land at press time + RD + k*RR while the hold, press mode and repeat_en persist.
    always @(posedge clock) begin
        m_out = '0;
        if (reset) begin
            p1 = '0;
            p2 = '0;
            m_held = '0;
            for (int c = 0; c < CH; c++) begin
                hist[c].delete();
                active[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                hist[c].push_back(p2[c]);
                if (hist[c].size() > DB) void'(hist[c].pop_front());
                stable = (hist[c].size() == DB);
                for (int k = 0; k < hist[c].size(); k++)
                    if (hist[c][k] == m_held[c]) stable = 0;
                rise = stable && !m_held[c];
                fall = stable && m_held[c];
                m_out[c] = bus.release_mode ? fall : rise;
                if (active[c] && (fall || !bus.repeat_en || bus.release_mode))
                    active[c] = 0;
                else if (active[c] && n - tp[c] >= RD && (n - tp[c] - RD) % RR == 0)
                    m_out[c] = 1'b1;
                if (rise && !bus.release_mode && bus.repeat_en) begin
                    active[c] = 1;
                    tp[c] = n;
                end
                if (stable) m_held[c] = ~m_held[c];
            end
            p2 = p1;
            p1 = bus.in;
        end
        n++;
        exp_q.push_back({m_out, m_held});
    end

    logic [2*CH-1:0] exp_v;
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at t=%0t: got out=%b held=%b, no expectation queued",
                         $time, bus.out, bus.held);
            end else begin
                exp_v = exp_q.pop_front();
                if ({bus.out, bus.held} !== exp_v) begin
                    errors++;
                    $display("FAIL out_held at t=%0t: got out=%b held=%b, expected out=%b held=%b",
                             $time, bus.out, bus.held, exp_v[2*CH-1:CH], exp_v[CH-1:0]);
                end
            end
        end
    end

    task automatic step(input logic [CH-1:0] v, input int k);
        repeat (k) begin
            bus.in = v;
            @(negedge clock);
        end
    endtask

    logic [CH-1:0] rv;
    initial begin
        bus.in = '0;
        bus.release_mode = 1'b0;
        bus.repeat_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        step(4'b0001, 20);
        step(4'b0000, 12);
        bus.release_mode = 1'b1;
        step(4'b0010, 8);
        step(4'b0000, 12);
        repeat (10) begin
            step(4'b0100, 3);
            step(4'b0000, 1);
        end
        step(4'b0100, 10);
        step(4'b0000, 10);
        bus.release_mode = 1'b0;
        bus.repeat_en = 1'b1;
        step(4'b1000, 30);
        step(4'b0000, 10);
        step(4'b1000, 18);
        bus.repeat_en = 1'b0;
        step(4'b1000, 10);
        step(4'b0000, 10);
        bus.repeat_en = 1'b1;
        bus.release_mode = 1'b1;
        step(4'b1000, 8);
        bus.release_mode = 1'b0;
        step(4'b1000, 20);
        step(4'b0000, 10);
        step(4'b0001, 4);
        reset = 1'b1;
        step(4'b0001, 2);
        reset = 1'b0;
        step(4'b0001, 12);
        step(4'b0000, 10);
        step(4'b1111, 12);
        step(4'b0000, 10);
        repeat (6) begin
            step(4'b0011, 2);
            step(4'b0001, 1);
        end
        step(4'b0001, 8);
        step(4'b0000, 10);
        for (int i = 0; i < 4000; i++) begin
            rv = bus.in;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 9) == 0) rv[c] = ~rv[c];
            if ($urandom_range(0, 199) == 0) bus.release_mode = ~bus.release_mode;
            if ($urandom_range(0, 149) == 0) bus.repeat_en = ~bus.repeat_en;
            reset = ($urandom_range(0, 499) == 0);
            step(rv, 1);
        end
        reset = 1'b0;
        step(4'b0000, 20);
        @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
